// File: rtl/tt_spi_regfile.sv
`timescale 1ns/1ps
// SPI mode-0 slave (16-bit command+data frames) in front of eight 8-bit registers with a registered view port.
// Build option SPI_FRAME_COUNTER_EN turns reg[7] into a read-only counter of completed write frames.
module tt_spi_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic       sclk_raw;
    logic       mosi_raw;
    logic       csn_raw;
    logic       sclk_meta_q;
    logic       sclk_sync_q;
    logic       sclk_prev_q;
    logic       mosi_meta_q;
    logic       mosi_sync_q;
    logic       csn_meta_q;
    logic       csn_sync_q;
    logic       csn_prev_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       csn_fall;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] bit_cnt_q;
    logic [3:0] bit_cnt_d;
    logic [6:0] rx_shift_q;
    logic [6:0] rx_shift_d;
    logic [7:0] tx_shift_q;
    logic [7:0] tx_shift_d;
    logic       cmd_wr_q;
    logic       cmd_wr_d;
    logic [2:0] cmd_addr_q;
    logic [2:0] cmd_addr_d;
    logic       miso_q;
    logic       miso_d;
    logic [7:0] uo_out_q;
    logic [7:0] uo_out_d;

    logic [7:0] rx_next;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] reg_rd [8];
    logic       unused_inputs;

    // Deselecting the design looks like an idle bus: CS_N high, SCLK and MOSI low.
    assign sclk_raw      = ena & ui_in[0];
    assign mosi_raw      = ena & ui_in[1];
    assign csn_raw       = ~ena | ui_in[2];
    assign unused_inputs = ^{uio_in, ui_in[7:6]};

    // Synchronizers reset low so a CS_N held low across reset release never reads as a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            csn_meta_q  <= 1'b0;
            csn_sync_q  <= 1'b0;
            csn_prev_q  <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_raw;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= mosi_raw;
            mosi_sync_q <= mosi_meta_q;
            csn_meta_q  <= csn_raw;
            csn_sync_q  <= csn_meta_q;
            csn_prev_q  <= csn_sync_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign csn_fall  = ~csn_sync_q & csn_prev_q;
    assign rx_next   = {rx_shift_q, mosi_sync_q};
    assign wr_addr   = cmd_addr_q;
    assign wr_data   = rx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'd0;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= 3'd0;
            miso_q     <= 1'b0;
            uo_out_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_addr_q <= cmd_addr_d;
            miso_q     <= miso_d;
            uo_out_q   <= uo_out_d;
        end
    end

    // A synchronized CS_N high is checked before any SCLK edge so a deselect always wins.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_addr_d = cmd_addr_q;
        miso_d     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_d    = ST_CMD;
                    bit_cnt_d  = 4'd0;
                    rx_shift_d = 7'd0;
                    tx_shift_d = 8'd0;
                end
            end
            ST_CMD: begin
                if (csn_sync_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next[6:0];
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d    = ST_DATA;
                        cmd_wr_d   = rx_next[7];
                        cmd_addr_d = rx_next[2:0];
                        if (!rx_next[7]) begin
                            tx_shift_d = reg_rd[rx_next[2:0]];
                        end
                    end
                end
            end
            ST_DATA: begin
                miso_d = miso_q;
                if (csn_sync_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    miso_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next[6:0];
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_DONE;
                        wr_en   = cmd_wr_q;
                        miso_d  = 1'b0;
                    end
                end else if (sclk_fall && !cmd_wr_q) begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (csn_sync_q) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
`ifdef SPI_FRAME_COUNTER_EN
            localparam bit IS_CNT = (gi == 7);
`else
            localparam bit IS_CNT = 1'b0;
`endif
            logic [7:0] val_q;
            logic [7:0] val_d;

            // The counter slot advances on every completed write frame and never takes write data.
            always_comb begin
                val_d = val_q;
                if (IS_CNT) begin
                    if (wr_en) begin
                        val_d = val_q + 8'd1;
                    end
                end else if (wr_en && (wr_addr == 3'(gi))) begin
                    val_d = wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_q <= 8'h00;
                end else begin
                    val_q <= val_d;
                end
            end

            assign reg_rd[gi] = val_q;
        end
    endgenerate

    always_comb begin
        uo_out_d = reg_rd[ui_in[5:3]];
    end

    assign uo_out  = uo_out_q;
    assign uio_out = {7'b0000000, miso_q};
    assign uio_oe  = 8'h01;

endmodule

// File: tb/tb_tt_spi_regfile.sv
`timescale 1ns/1ps
// Randomized SPI-master bench for tt_spi_regfile: stimulus pushes expectations, monitors pop and compare.
module tb_tt_spi_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_spi_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    localparam int H = 5;  // SCLK half period in clk cycles

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mdl_reg [8];

    logic       miso_exp_q [$];
    int         miso_idx_q [$];
    int         view_which_q [$];
    logic [7:0] view_val_q [$];
    string      view_name_q [$];
    event       view_ev;
    logic       sclk_seen = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_reg[i] = 8'h00;
    endtask

    task automatic mdl_write(input logic [7:0] cmd, input logic [7:0] data);
        if (!cmd[7] || !ena) return;
`ifdef SPI_FRAME_COUNTER_EN
        mdl_reg[7] = mdl_reg[7] + 8'd1;
        if (cmd[2:0] != 3'd7) mdl_reg[cmd[2:0]] = data;
`else
        mdl_reg[cmd[2:0]] = data;
`endif
    endtask

    // Bit i of the frame (0-based rising edge): data bits of a read are the register MSB first.
    function automatic logic exp_miso(input logic [7:0] cmd, input logic [7:0] rd, input int i);
        if (cmd[7] || i < 8 || i >= 16) return 1'b0;
        return rd[15 - i];
    endfunction

    task automatic push_view(input int which, input logic [7:0] val, input string name);
        view_which_q.push_back(which);
        view_val_q.push_back(val);
        view_name_q.push_back(name);
        -> view_ev;
        tick(1);
    endtask

    task automatic check_view(input int addr);
        ui_in[5:3] = 3'(addr);
        tick(2);
        push_view(0, mdl_reg[addr], $sformatf("uo_out_reg%0d", addr));
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] extra,
                             input int nbits, input bit rst_mid);
        logic [23:0] bits;
        logic [7:0]  rd;
        bits = {cmd, data, extra};
        rd   = mdl_reg[cmd[2:0]];
        $display("frame cmd=%02h data=%02h extra=%02h bits=%0d ena=%0b rst_mid=%0b",
                 cmd, data, extra, nbits, ena, rst_mid);
        ui_in[0] = 1'b0;
        ui_in[2] = 1'b0;
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            ui_in[1] = bits[23 - i];
            tick(H);
            miso_exp_q.push_back(exp_miso(cmd, rd, i));
            miso_idx_q.push_back(i);
            ui_in[0] = 1'b1;
            tick(H);
            ui_in[0] = 1'b0;
        end
        tick(H);
        if (rst_mid) begin
            rst_n = 1'b0;
            mdl_reset();
            tick(3);
            push_view(0, 8'h00, "uo_out_in_reset");
            push_view(1, 8'h00, "uio_out_in_reset");
            rst_n = 1'b1;
            tick(6);
        end else if (nbits >= 16) begin
            mdl_write(cmd, data);
        end
        ui_in[2] = 1'b1;
        tick(4 * H);
    endtask

    // MISO monitor: samples like a mode-0 master on every SCLK rise while selected.
    initial begin
        forever begin
            @(negedge clk);
            if (!ui_in[2] && ui_in[0] && !sclk_seen) begin
                n_vec++;
                if (miso_exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL miso_unexpected: got %02h required no sample", uio_out);
                end else begin
                    logic exp_b;
                    int   idx;
                    exp_b = miso_exp_q.pop_front();
                    idx   = miso_idx_q.pop_front();
                    if (uio_out !== {7'b0000000, exp_b}) begin
                        n_err++;
                        $display("FAIL miso_bit%0d: uio_out got %02h required %02h",
                                 idx, uio_out, {7'b0000000, exp_b});
                    end
                end
            end
            sclk_seen = ui_in[0];
        end
    end

    // Output-port monitor: compares the requested port against the next queued expectation.
    initial begin
        forever begin
            @(view_ev);
            @(negedge clk);
            n_vec++;
            if (view_val_q.size() == 0) begin
                n_err++;
                $display("FAIL view_unexpected: no expectation queued");
            end else begin
                int         which;
                logic [7:0] exp_v;
                logic [7:0] act_v;
                string      name;
                which = view_which_q.pop_front();
                exp_v = view_val_q.pop_front();
                name  = view_name_q.pop_front();
                act_v = (which == 0) ? uo_out : (which == 1) ? uio_out : uio_oe;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL %s: got %02h required %02h", name, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h04;
        uio_in = 8'h00;
        mdl_reset();
        tick(3);
        push_view(0, 8'h00, "reset_uo_out");
        push_view(1, 8'h00, "reset_uio_out");
        push_view(2, 8'h01, "reset_uio_oe");
        rst_n = 1'b1;
        tick(5);

        // Basic write and view.
        spi_frame(8'h80, 8'hA5, 8'h00, 16, 1'b0);
        check_view(0);

        // Write then read back over MISO.
        spi_frame(8'h83, 8'h3C, 8'h00, 16, 1'b0);
        spi_frame(8'h03, 8'h00, 8'h00, 16, 1'b0);
        check_view(3);

        // Abort after 4 data bits, then a full frame must still work.
        spi_frame(8'h81, 8'hF0, 8'h00, 12, 1'b0);
        check_view(1);
        spi_frame(8'h81, 8'h5A, 8'h00, 16, 1'b0);
        check_view(1);
        spi_frame(8'h01, 8'h00, 8'h00, 16, 1'b0);

        // Over-long frame: trailing bits are ignored.
        spi_frame(8'h84, 8'h11, 8'hFF, 24, 1'b0);
        check_view(4);

        // Deselected design ignores the bus.
        ena = 1'b0;
        spi_frame(8'h85, 8'h77, 8'h00, 16, 1'b0);
        ena = 1'b1;
        tick(4);
        check_view(5);

        // Reset in the middle of a write frame.
        spi_frame(8'h82, 8'h55, 8'h00, 16, 1'b0);
        check_view(2);
        spi_frame(8'h82, 8'hFF, 8'h00, 10, 1'b1);
        check_view(2);
        check_view(0);
        spi_frame(8'h82, 8'h66, 8'h00, 16, 1'b0);
        check_view(2);

        // Randomized frames: full, aborted and over-long.
        for (int k = 0; k < 30; k++) begin
            logic [7:0] c;
            logic [7:0] d;
            logic [7:0] e;
            int         r;
            int         nb;
            c  = 8'($urandom);
            d  = 8'($urandom);
            e  = 8'($urandom);
            r  = int'($urandom_range(0, 9));
            nb = (r < 6) ? 16 : (r < 8) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 24));
            spi_frame(c, d, e, nb, 1'b0);
            check_view(int'($urandom_range(0, 7)));
        end

        // Read every register back over SPI.
        for (int a = 0; a < 8; a++) begin
            logic [7:0] c;
            c = {1'b0, 4'($urandom), 3'(a)};
            spi_frame(c, 8'($urandom), 8'h00, 16, 1'b0);
            check_view(a);
        end

`ifdef SPI_FRAME_COUNTER_EN
        rst_n = 1'b0;
        mdl_reset();
        tick(2);
        rst_n = 1'b1;
        tick(4);
        for (int k = 0; k < 3; k++) begin
            spi_frame({1'b1, 4'($urandom), 3'($urandom)}, 8'($urandom), 8'h00, 16, 1'b0);
        end
        check_view(7);
        spi_frame(8'h07, 8'h00, 8'h00, 16, 1'b0);
        for (int k = 0; k < 253; k++) begin
            spi_frame({1'b1, 4'($urandom), 3'($urandom)}, 8'($urandom), 8'h00, 16, 1'b0);
        end
        check_view(7);
`endif

        for (int t = 0; t < 100 && (view_val_q.size() != 0 || miso_exp_q.size() != 0); t++) tick(1);
        n_vec++;
        if (view_val_q.size() != 0 || miso_exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d view and %0d miso expectations left, required 0",
                     view_val_q.size(), miso_exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_spi_regfile.md
TT_SPI_REGFILE -- requirements
Module: tt_spi_regfile

Interface
REQ-001 SHALL declare port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL declare port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL declare port ena, input, 1, design select; while low, the SPI inputs are treated as CS_N=1.
REQ-004 SHALL declare port ui_in, input, 8: [0]=SCLK, [1]=MOSI, [2]=CS_N (active-low), [5:3]=view select, [7:6] unused.
REQ-005 SHALL declare port uo_out, output, 8, registered copy of the register chosen by ui_in[5:3].
REQ-006 SHALL declare port uio_in, input, 8, ignored.
REQ-007 SHALL declare port uio_out, output, 8: [0]=MISO, [7:1] tied 0.
REQ-008 SHALL declare port uio_oe, output, 8, constant 8'h01.

Function
REQ-009 SHALL pass SCLK, MOSI and CS_N through 2-flop synchronizers, and detect SCLK rising and falling edges on the synchronized value; supported SCLK <= clk/8.
REQ-010 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first, 16-bit frame: command byte then data byte.
REQ-011 SHALL decode the command byte as: bit7=1 write, 0 read; bits[2:0]=address; bits[6:3] ignored.
REQ-012 SHALL hold eight 8-bit registers, reg[0..7].
REQ-013 SHALL implement FSM IDLE -> CMD (synced CS_N falling) -> DATA (8th rising edge) -> DONE (16th rising edge) -> IDLE (synced CS_N high).
REQ-014 SHALL, on a write frame, update reg[addr] with the data byte in the clk cycle the 16th synchronized rising edge is detected.
REQ-015 SHALL, on a read frame, load reg[addr] into the TX shifter at the 8th rising edge, drive its MSB on MISO at the following falling edge, and shift on each later falling edge; 8 data bits total.
REQ-016 SHALL drive MISO=0 in IDLE, CMD, DONE, and during a write frame.
REQ-017 SHALL abort with no register change and return to IDLE if CS_N rises before the 16th rising edge.
REQ-018 SHALL ignore SCLK edges in DONE; extra bits beyond 16 have no effect.
REQ-019 SHALL update uo_out one clk after any change of ui_in[5:3] or of the selected register.
REQ-020 SHALL treat a CS_N rise and a SCLK edge detected in the same cycle as CS_N rise winning.

Reset
REQ-021 SHALL, while rst_n=0, force FSM=IDLE, all reg[]=8'h00, bit counter=0, shifters=0, uo_out=8'h00 and uio_out=8'h00; uio_oe stays 8'h01.
REQ-022 SHALL discard any frame in progress on reset; the next frame begins only after a fresh CS_N fall following rst_n release.

Configuration
REQ-023 SHALL, with SPI_FRAME_COUNTER_EN defined, make reg[7] a read-only count of completed write frames, +1 per frame, wrapping 8'hFF->8'h00; writes to address 7 are counted but do not store data.
REQ-024 SHALL, without SPI_FRAME_COUNTER_EN, make reg[7] an ordinary read/write register.

Verification
REQ-025 SHALL cover: write 0x80,0xA5 (writing 0xA5 to reg[0]); ui_in[5:3]=0 -> uo_out=0xA5.
REQ-026 SHALL cover: write 0x83,0x3C, then read frame 0x03,0x00 -> MISO bits 0,0,1,1,1,1,0,0.
REQ-027 SHALL cover: write 0x81, then 4 data bits, then CS_N high -> reg[1] stays 0x00, FSM back in IDLE.
REQ-028 SHALL cover: with SPI_FRAME_COUNTER_EN, 3 write frames -> reg[7]=0x03; 256 frames -> 0x00.
REQ-029 SHALL cover: rst_n low after 10 bits of write 0x82,0xFF -> reg[2]=0x00, uo_out=0x00; the next full frame succeeds.
REQ-030 SHALL cover: a 24-bit frame writing 0x84,0x11 followed by 0xFF -> reg[4]=0x11.
